pipe_ctrl: RTL

Central pipeline controller for the 5-stage core. It arbitrates stall requests from the IF fetch handshake, the ID load-use check, the EX multi-cycle unit and the MEM bus wait into one per-stage stall vector. It also sequences multi-cycle EX operations with an internal countdown. On an exception or return-from-exception it flushes all pipeline registers, supplies the redirect PC and drains any in-flight fetch.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl_mc_counter.sv | 28 ++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall vectors,
// controller state encoding and the default exception vector.
package pipe_ctrl_pkg;

  // Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIF   = 6'b000011;
  localparam logic [5:0] StallID   = 6'b000111;
  localparam logic [5:0] StallEX   = 6'b001111;
  localparam logic [5:0] StallMEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MC    = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  logic        if_req_i;
  logic        if_ack_i;
  logic        id_stallreq_i;
  logic        ex_mc_start_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        exc_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        if_discard_o;
  logic        mc_busy_o;
  logic        mc_done_o;

  modport master (
    output if_req_i, if_ack_i, id_stallreq_i, ex_mc_start_i,
           mem_req_i, mem_ack_i, exc_i, eret_i, epc_i,
    input  stall_o, flush_o, new_pc_o, if_discard_o, mc_busy_o, mc_done_o
  );

  modport slave (
    input  if_req_i, if_ack_i, id_stallreq_i, ex_mc_start_i,
           mem_req_i, mem_ack_i, exc_i, eret_i, epc_i,
    output stall_o, flush_o, new_pc_o, if_discard_o, mc_busy_o, mc_done_o
  );
endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle op countdown: load, saturating decrement, clear, zero flag.
module mc_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into one stall vector,
// sequences multi-cycle EX ops and handles exception/eret flush and fetch drain.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_CYCLES  = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MC_CYCLES);

  state_t r_state;
  state_t w_state_next;
  logic   w_flush;
  logic   w_if_wait;
  logic   w_mem_wait;
  logic   w_zero;
  logic   w_load;
  logic   w_dec;
  logic   w_clr;
  logic   w_done;
  logic   w_discard;
  logic [5:0] w_stall;

  assign w_flush    = bus.exc_i | bus.eret_i;
  assign w_if_wait  = bus.if_req_i & ~bus.if_ack_i;
  assign w_mem_wait = bus.mem_req_i & ~bus.mem_ack_i;

  mc_counter #(.WIDTH(CNT_W)) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_W'(MC_CYCLES - 1)),
    .i_dec      (w_dec),
    .i_clr      (w_clr),
    .o_zero     (w_zero)
  );

  // Priority stall merge, highest first
  always_comb begin
    w_stall = StallNone;
    if (w_flush) begin
      w_stall = StallNone;
    end else if (w_mem_wait) begin
      w_stall = StallMEM;
    end else if ((r_state == MC) && !w_zero) begin
      w_stall = StallEX;
    end else if (bus.id_stallreq_i) begin
      w_stall = StallID;
    end else if (w_if_wait || (r_state == DRAIN)) begin
      w_stall = StallIF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_clr        = 1'b0;
    w_done       = 1'b0;
    w_discard    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_flush) begin
          w_state_next = w_if_wait ? DRAIN : RUN;
        end else if (bus.ex_mc_start_i) begin
          w_state_next = MC;
          w_load       = 1'b1;
        end
      end
      MC: begin
        if (w_flush) begin
          w_clr        = 1'b1;
          w_state_next = w_if_wait ? DRAIN : RUN;
        end else begin
          w_dec = 1'b1;
          // A MEM stall at cnt==0 holds the commit until the bus completes
          if (w_zero && !w_stall[4]) begin
            w_done       = 1'b1;
            w_state_next = RUN;
          end
        end
      end
      DRAIN: begin
        w_discard = bus.if_ack_i;
        if (!w_flush && bus.if_ack_i) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  assign bus.stall_o      = w_stall;
  assign bus.flush_o      = w_flush;
  assign bus.new_pc_o     = bus.exc_i ? EXC_VECTOR : (bus.eret_i ? bus.epc_i : 32'h0);
  assign bus.if_discard_o = w_discard;
  assign bus.mc_busy_o    = (r_state == MC);
  assign bus.mc_done_o    = w_done;

  a_no_restart : assert property (@(posedge clk) disable iff (rst)
    !((r_state == MC) && bus.ex_mc_start_i));

endmodule
